// File: rtl/bpsk_pkg.sv
// Shared constants for the BPSK modulator, derived from the params.vh macros
// (the fallback values below are used when params.vh has not been included).
`ifndef CARRIER_SAMPLES_PER_PERIOD
`define CARRIER_SAMPLES_PER_PERIOD 64
`endif
`ifndef SAMPLING_FREQ
`define SAMPLING_FREQ 64
`endif
`ifndef CARRIER_FREQ
`define CARRIER_FREQ 8
`endif
`ifndef SAMPLES_PER_SYMBOL
`define SAMPLES_PER_SYMBOL 8
`endif
`ifndef FIXDT_64_A_WIDTH
`define FIXDT_64_A_WIDTH 16
`endif

package bpsk_pkg;
  localparam int CARRIER_SPP    = `CARRIER_SAMPLES_PER_PERIOD;
  localparam int PHASE_W_DEF    = $clog2(CARRIER_SPP);
  localparam int PHASE_STEP_DEF = CARRIER_SPP / (`SAMPLING_FREQ / `CARRIER_FREQ);
  localparam int SPS_DEF        = `SAMPLES_PER_SYMBOL;
  localparam int DATA_W         = `FIXDT_64_A_WIDTH;

  typedef logic [0:0] bpsk_state_t;
  localparam bpsk_state_t ST_IDLE = 1'b0;
  localparam bpsk_state_t ST_TX   = 1'b1;
endpackage

// File: rtl/cosine_lut.sv
// 64-entry cosine ROM (Q1.15) built from a 17-entry quarter wave; each read port
// uses the top 6 bits of its address.
module cosine_lut #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 16,
  parameter int READ_PORTS = 1
) (
  input  logic [READ_PORTS-1:0][ADDR_W-1:0] addr,
  output logic [READ_PORTS-1:0][DATA_W-1:0] data
);

  function automatic logic signed [15:0] quarter(input logic [4:0] r);
    logic signed [15:0] v;
    case (r)
      5'd0:    v = 16'sd32767;
      5'd1:    v = 16'sd32609;
      5'd2:    v = 16'sd32137;
      5'd3:    v = 16'sd31356;
      5'd4:    v = 16'sd30273;
      5'd5:    v = 16'sd28898;
      5'd6:    v = 16'sd27245;
      5'd7:    v = 16'sd25329;
      5'd8:    v = 16'sd23170;
      5'd9:    v = 16'sd20787;
      5'd10:   v = 16'sd18204;
      5'd11:   v = 16'sd15446;
      5'd12:   v = 16'sd12539;
      5'd13:   v = 16'sd9512;
      5'd14:   v = 16'sd6393;
      5'd15:   v = 16'sd3212;
      default: v = 16'sd0;
    endcase
    return v;
  endfunction

  // Quadrant folding: mirror the index in quadrants 1/3, negate in quadrants 1/2.
  function automatic logic signed [15:0] cos64(input logic [5:0] i);
    logic [4:0] r;
    logic [4:0] rr;
    logic signed [15:0] v;
    r  = {1'b0, i[3:0]};
    rr = 5'd16 - r;
    case (i[5:4])
      2'd0:    v = quarter(r);
      2'd1:    v = -quarter(rr);
      2'd2:    v = -quarter(r);
      default: v = quarter(rr);
    endcase
    return v;
  endfunction

  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      data[p] = DATA_W'(cos64(addr[p][ADDR_W-1 -: 6]));
    end
  end

endmodule

// File: rtl/bpsk_modulator_top.sv
// BPSK modulator: free-running carrier phase, one symbol of SPS cos/-cos samples per bit.
// Optional differential encoding is enabled by defining BPSK_MOD_DIFF_EN.
module bpsk_modulator_top
  import bpsk_pkg::*;
#(
  parameter int PHASE_W    = PHASE_W_DEF,
  parameter int PHASE_STEP = PHASE_STEP_DEF,
  parameter int SPS        = SPS_DEF,
  parameter int INIT_PHASE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tx_en,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic                     bit_ready,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     data_out_valid,
  output logic                     symbol_strobe
);

  localparam int CNT_W = (SPS > 2) ? $clog2(SPS) : 1;
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(SPS - 1);
  localparam logic [PHASE_W-1:0] STEP_C   = PHASE_W'(PHASE_STEP);
  localparam logic [PHASE_W-1:0] INIT_C   = PHASE_W'(INIT_PHASE);
  localparam logic signed [DATA_W-1:0] MAX_C = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_C = {1'b1, {(DATA_W-1){1'b0}}};

  bpsk_state_t               state;
  logic [CNT_W-1:0]          sample_cnt;
  logic [PHASE_W-1:0]        acc;
  logic                      sym_q;
  logic [0:0][DATA_W-1:0]    lut_data;
  logic signed [DATA_W-1:0]  cos_val;
  logic signed [DATA_W-1:0]  neg_cos;
  logic                      last_sample;
  logic                      accept;
  logic                      tx_sym;
  logic                      out_sym;
  logic                      continue_sym;

  cosine_lut #(
    .ADDR_W     (PHASE_W),
    .DATA_W     (DATA_W),
    .READ_PORTS (1)
  ) u_lut (
    .addr (acc),
    .data (lut_data)
  );

  // The output register holds the sample for the next cycle, so decisions here
  // look at what the coming cycle must show (latency of one from accept).
  always_comb begin
    cos_val      = $signed(lut_data[0]);
    neg_cos      = (cos_val == MIN_C) ? MAX_C : -cos_val;
    last_sample  = (sample_cnt == LAST_CNT);
    bit_ready    = rst_n && tx_en && ((state == ST_IDLE) || last_sample);
    accept       = bit_valid && bit_ready;
`ifdef BPSK_MOD_DIFF_EN
    tx_sym       = bit_in ^ sym_q;
`else
    tx_sym       = bit_in;
`endif
    out_sym      = accept ? tx_sym : sym_q;
    continue_sym = (state == ST_TX) && !last_sample;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      sample_cnt     <= '0;
      acc            <= INIT_C;
      sym_q          <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      symbol_strobe  <= 1'b0;
    end else begin
      acc <= acc + STEP_C;
      if (accept) begin
        state      <= ST_TX;
        sample_cnt <= '0;
        sym_q      <= tx_sym;
      end else if (state == ST_TX) begin
        if (last_sample) begin
          state      <= ST_IDLE;
          sample_cnt <= '0;
        end else begin
          sample_cnt <= sample_cnt + 1'b1;
        end
      end
      data_out_valid <= accept || continue_sym;
      symbol_strobe  <= accept;
      if (accept || continue_sym) begin
        data_out <= out_sym ? neg_cos : cos_val;
      end else begin
        data_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bpsk_modulator_top.sv
// Randomized and directed bench for bpsk_modulator_top; a queue of expected
// samples (symbol sign, carrier phase, strobe) is built on each accepted bit.
module tb_bpsk_modulator_top;
  import bpsk_pkg::*;

  localparam int SPS    = SPS_DEF;
  localparam int STEP   = PHASE_STEP_DEF;
  localparam int PMOD   = 1 << PHASE_W_DEF;
  localparam int INIT   = 0;
  localparam int TOL    = 2;

  typedef struct {
    logic neg;
    int   phase;
    logic strobe;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     tx_en = 1'b0;
  logic                     bit_in = 1'b0;
  logic                     bit_valid = 1'b0;
  logic                     bit_ready;
  logic signed [DATA_W-1:0] data_out;
  logic                     data_out_valid;
  logic                     symbol_strobe;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  int   model_phase = INIT;
  logic model_prev = 1'b0;

  bpsk_modulator_top #(
    .PHASE_W    (PHASE_W_DEF),
    .PHASE_STEP (PHASE_STEP_DEF),
    .SPS        (SPS_DEF),
    .INIT_PHASE (INIT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tx_en          (tx_en),
    .bit_in         (bit_in),
    .bit_valid      (bit_valid),
    .bit_ready      (bit_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .symbol_strobe  (symbol_strobe)
  );

  always #5 clk = ~clk;

  function automatic int cos_ref(input int p, input logic neg);
    real a;
    int  v;
    a = 2.0 * 3.14159265358979 * real'(p) / real'(PMOD);
    v = int'($floor(32767.0 * $cos(a) + 0.5));
    if (neg) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  // One clock cycle: drive inputs, check readiness, advance, check the visible sample.
  task automatic step(input logic en, input logic b, input logic v, input logic rn,
                      output logic accepted);
    logic exp_ready;
    logic sym;
    exp_t e;
    int   d;
    int   want;
    tx_en = en; bit_in = b; bit_valid = v; rst_n = rn;
    #1;
    exp_ready = rn && en && (q.size() == 0);
    checks++;
    if (bit_ready !== exp_ready) begin
      errors++;
      $display("[TB] FAIL bit_ready: got %b want %b at %0t", bit_ready, exp_ready, $time);
    end
    accepted = v && exp_ready;
    if (accepted) begin
`ifdef BPSK_MOD_DIFF_EN
      sym = b ^ model_prev;
`else
      sym = b;
`endif
      model_prev = sym;
      for (int j = 0; j < SPS; j++) begin
        q.push_back('{neg: sym, phase: (model_phase + j * STEP) % PMOD, strobe: (j == 0)});
      end
    end
    @(posedge clk);
    if (!rn) begin
      q.delete();
      model_phase = INIT;
      model_prev  = 1'b0;
    end else begin
      model_phase = (model_phase + STEP) % PMOD;
    end
    #1;
    if (q.size() > 0) e = q.pop_front();
    else e = '{neg: 1'b0, phase: -1, strobe: 1'b0};
    checks++;
    if (data_out_valid !== (e.phase >= 0)) begin
      errors++;
      $display("[TB] FAIL data_out_valid: got %b want %b at %0t", data_out_valid, (e.phase >= 0), $time);
    end
    checks++;
    if (symbol_strobe !== e.strobe) begin
      errors++;
      $display("[TB] FAIL symbol_strobe: got %b want %b at %0t", symbol_strobe, e.strobe, $time);
    end
    d    = int'(data_out);
    want = (e.phase >= 0) ? cos_ref(e.phase, e.neg) : 0;
    checks++;
    if ($isunknown(data_out) || (d - want > TOL) || (want - d > TOL)) begin
      errors++;
      $display("[TB] FAIL data_out: got %0d want %0d (+/-%0d) at %0t", d, want, TOL, $time);
    end
  endtask

  task automatic test_reset();
    logic a;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, a);
  endtask

  task automatic test_single_symbol();
    logic a;
    test_reset();
    step(1'b1, 1'b0, 1'b1, 1'b1, a);
    for (int i = 0; i < SPS + 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, a);
  endtask

  task automatic run_bits(input logic [2:0] bits, input bit sign_check, input logic [2:0] want_neg);
    logic a;
    int   idx;
    int   strobes;
    idx = 0;
    strobes = 0;
    for (int c = 0; c < 3 * SPS + 4; c++) begin
      step(1'b1, bits[idx < 3 ? idx : 0], idx < 3, 1'b1, a);
      if (a) idx++;
      if (sign_check && symbol_strobe === 1'b1 && strobes < 3) begin
        checks++;
        if ((data_out < 0) !== want_neg[strobes]) begin
          errors++;
          $display("[TB] FAIL symbol_sign[%0d]: got neg=%b want neg=%b", strobes, (data_out < 0), want_neg[strobes]);
        end
        strobes++;
      end
    end
    checks++;
    if (idx != 3) begin
      errors++;
      $display("[TB] FAIL accept_count: got %0d want 3", idx);
    end
  endtask

  task automatic test_back_to_back();
    test_reset();
    run_bits(3'b101, 1'b0, 3'b000);
  endtask

  task automatic test_tx_en_drop();
    logic a;
    test_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1, a);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, a);
    for (int i = 0; i < SPS + 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, a);
  endtask

  task automatic test_reset_mid();
    logic a;
    test_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1, a);
    for (int i = 0; i < SPS / 2; i++) step(1'b1, 1'b0, 1'b0, 1'b1, a);
    step(1'b1, 1'b0, 1'b1, 1'b0, a);
    step(1'b1, 1'b0, 1'b1, 1'b1, a);
    for (int i = 0; i < SPS + 2; i++) step(1'b1, 1'b1, 1'b0, 1'b1, a);
  endtask

  task automatic test_diff_signs();
    test_reset();
`ifdef BPSK_MOD_DIFF_EN
    run_bits(3'b011, 1'b1, 3'b001);
`else
    run_bits(3'b011, 1'b1, 3'b011);
`endif
  endtask

  task automatic test_random();
    logic a;
    test_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 7) != 0, 1'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 79) != 0, a);
    end
  endtask

  initial begin
    test_reset();
    test_single_symbol();
    test_back_to_back();
    test_tx_en_drop();
    test_reset_mid();
    test_diff_signs();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bpsk_modulator_top.md
BPSK_MODULATOR_TOP -- requirements
Module: bpsk_modulator_top

Interface
REQ-001 SHALL have parameter PHASE_W, default $clog2(`CARRIER_SAMPLES_PER_PERIOD), phase accumulator width.
REQ-002 SHALL have parameter PHASE_STEP, default `CARRIER_SAMPLES_PER_PERIOD/(`SAMPLING_FREQ/`CARRIER_FREQ), accumulator increment per clk.
REQ-003 SHALL have parameter SPS, default `SAMPLES_PER_SYMBOL, samples per symbol (>=2).
REQ-004 SHALL have parameter INIT_PHASE, default 0, accumulator value loaded at reset.
REQ-005 SHALL have port clk  input  1  clock, all logic on posedge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port tx_en  input  1  enables acceptance of new bits.
REQ-008 SHALL have port bit_in  input  1  data bit to transmit.
REQ-009 SHALL have port bit_valid  input  1  bit_in is valid.
REQ-010 SHALL have port bit_ready  output  1  module accepts bit_in this cycle.
REQ-011 SHALL have port data_out  output  signed `FIXDT_64_A_WIDTH  modulated carrier sample.
REQ-012 SHALL have port data_out_valid  output  1  data_out carries a symbol sample.
REQ-013 SHALL have port symbol_strobe  output  1  high on the first sample of each symbol.

Function
REQ-014 SHALL hold a PHASE_W-bit accumulator advancing by PHASE_STEP every cycle (wrap modulo 2^PHASE_W), free-running in all states so carrier phase is continuous.
REQ-015 SHALL look up cos(accumulator) via one cosine_lut read port and register the result into data_out.
REQ-016 SHALL implement FSM IDLE/TX; IDLE->TX on bit accept; TX->TX on accept in last sample; TX->IDLE at last sample with no accept.
REQ-017 SHALL drive bit_ready = tx_en && (state==IDLE || sample_cnt==SPS-1); accept = bit_valid && bit_ready.
REQ-018 SHALL on accept latch the symbol bit and clear sample_cnt to 0; sample_cnt increments each TX cycle up to SPS-1.
REQ-019 SHALL output data_out = cos for symbol 0, -cos for symbol 1, one cycle after accept (latency 1), data_out_valid=1 for exactly SPS cycles per symbol.
REQ-020 SHALL saturate negation of the most-negative code to the most-positive code.
REQ-021 SHALL drive data_out=0, data_out_valid=0 while IDLE.
REQ-022 SHALL assert symbol_strobe with the first data_out_valid cycle of each symbol only.
REQ-023 SHALL complete the current symbol when tx_en falls mid-symbol, then go IDLE.
REQ-024 SHALL produce gapless back-to-back symbols when a bit is accepted at sample_cnt==SPS-1.
REQ-025 SHALL ignore bit_in/bit_valid when bit_ready=0.

Reset
REQ-026 SHALL on rst_n=0 at posedge set state=IDLE, sample_cnt=0, accumulator=INIT_PHASE, data_out=0, data_out_valid=0, symbol_strobe=0, symbol register=0.
REQ-027 SHALL hold bit_ready=0 while rst_n=0.
REQ-028 SHALL abort any symbol in progress on reset mid-operation, outputs at reset values from the next cycle.

Configuration
REQ-029 SHALL, with BPSK_MOD_DIFF_EN defined, transmit symbol = bit_in XOR previous transmitted symbol (previous cleared only by reset, retained across IDLE).
REQ-030 SHALL, without BPSK_MOD_DIFF_EN, transmit symbol = bit_in directly, with no extra state.

Structure
REQ-031 SHALL take PHASE_W, PHASE_STEP, SPS defaults and the FSM state enum from shared package bpsk_pkg (derived from params.vh).
REQ-032 SHALL instantiate existing cosine_lut (READ_PORTS=1) as its single sub-module; no other sub-modules.

Verification
REQ-033 Reset, INIT_PHASE=0, tx_en=1, bit 0 valid at cycle 0 -> data_out from cycle 1 equals cosine_lut(0), cosine_lut(PHASE_STEP), ...; data_out_valid high SPS cycles, symbol_strobe cycle 1 only.
REQ-034 Bits 1,0,1 held valid continuously -> data_out_valid high 3*SPS consecutive cycles, data_out sign-inverted vs cos for symbols 1 and 3, bit_ready high only at sample_cnt==SPS-1.
REQ-035 tx_en=0 mid-symbol with bit_valid=1 -> symbol finishes SPS samples, no new accept, then data_out=0, data_out_valid=0.
REQ-036 rst_n=0 at sample SPS/2 -> next cycle data_out=0, data_out_valid=0, accumulator=INIT_PHASE, bit_ready=0.
REQ-037 BPSK_MOD_DIFF_EN defined, bits 1,1,0 -> transmitted symbols 1,0,0 (signs -,+,+); undefined -> signs -,-,+.
REQ-038 Loopback into bpsk_demodulator_top with 1000 random bits -> demodulated data_out sequence matches input bits after demodulator lock.
